sync_reg_queue: RTL and testbench

Parametrised single-clock successor to the existing synchronising data register: instead of one 8-bit holding register with a single `r_empty` flag, it buffers up to `DEPTH` words of `WIDTH` bits in first-word-fall-through order. It exposes full, almost-full and occupancy status so producers can apply back-pressure. It sits between a byte/word producer (e.g. a serial receiver) and a consumer running on the same clock.

---
 rtl/sync_reg_pkg.sv | 21 ++
 rtl/sync_reg_mem.sv | 32 +++
 rtl/sync_reg_queue.sv | 134 +++++++++++++
 tb/tb_sync_reg_queue.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/sync_reg_pkg.sv
// sync_reg_pkg
//   Shared constants and width helpers for the synchronising register queue.
//   - SYNC_REG_DEFAULT_WIDTH : default data word width
//   - SYNC_REG_DEFAULT_DEPTH : default number of entries (power of two)
//   - ptr_w(depth)           : pointer width including the wrap bit
//   - cnt_w(depth)           : occupancy counter width, holds 0..depth
package sync_reg_pkg;

  localparam int SYNC_REG_DEFAULT_WIDTH = 8;
  localparam int SYNC_REG_DEFAULT_DEPTH = 8;

  // Address bits plus one wrap bit, so full and empty are distinguishable.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_reg_mem.sv
// sync_reg_mem
//   DEPTH x WIDTH storage, one synchronous write port and one asynchronous
//   read port. Contents are not reset.
//   Ports:
//     clk     in   write clock (rising edge)
//     we      in   write enable
//     waddr   in   write address
//     wdata   in   write data
//     raddr   in   read address
//     rdata   out  combinational read of mem[raddr]
module sync_reg_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_reg_queue.sv
// sync_reg_queue
//   First-word-fall-through queue of DEPTH words of WIDTH bits on one clock.
//   Handshake: a write is taken when w_en is high and the queue is not full,
//   or when a read is taken in the same cycle; a read is taken when r_en is
//   high and the queue is not empty. Rejected requests leave no trace except
//   the optional sticky error flags.
//   Optional feature macro: SYNC_REG_Q_ERR_EN adds err_ovf / err_udf.
//   Ports:
//     clk      in   clock, rising edge
//     rst      in   asynchronous active-low reset
//     w_en     in   write request
//     w_data   in   write data
//     r_en     in   pop request
//     r_data   out  head entry (valid while r_empty = 0)
//     r_empty  out  queue empty (registered)
//     w_full   out  queue full (registered)
//     w_afull  out  count >= AF_LEVEL (registered)
//     count    out  occupancy 0..DEPTH (registered)
//     err_ovf  out  sticky overflow  (SYNC_REG_Q_ERR_EN only)
//     err_udf  out  sticky underflow (SYNC_REG_Q_ERR_EN only)
module sync_reg_queue
  import sync_reg_pkg::*;
#(
  parameter int WIDTH    = SYNC_REG_DEFAULT_WIDTH,
  parameter int DEPTH    = SYNC_REG_DEFAULT_DEPTH,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      w_en,
  input  logic [WIDTH-1:0]          w_data,
  input  logic                      r_en,
  output logic [WIDTH-1:0]          r_data,
  output logic                      r_empty,
  output logic                      w_full,
  output logic                      w_afull,
  output logic [cnt_w(DEPTH)-1:0]   count
`ifdef SYNC_REG_Q_ERR_EN
  ,
  output logic                      err_ovf,
  output logic                      err_udf
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [CW-1:0] AF_C = CW'(AF_LEVEL);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic          r_acc, w_acc;

  // Gating the write on r_acc (not r_en) keeps full+simultaneous-read legal
  // while an empty-queue read never lets a write bypass into the same cycle.
  assign r_acc = r_en && !empty_q;
  assign w_acc = w_en && (!full_q || r_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_acc) wr_ptr_d = wr_ptr_q + PW'(1);
    if (r_acc) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({w_acc, r_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Flags come from next-state pointers so they are registered glitch-free.
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) &&
              (wr_ptr_d[AW] != rd_ptr_d[AW]);
    afull_d = (count_d >= AF_C);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
    end
  end

  sync_reg_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (w_acc),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (w_data),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (r_data)
  );

  assign r_empty = empty_q;
  assign w_full  = full_q;
  assign w_afull = afull_q;
  assign count   = count_q;

`ifdef SYNC_REG_Q_ERR_EN
  logic ovf_q, udf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (w_en && full_q && !r_acc) ovf_q <= 1'b1;
      if (r_en && empty_q)          udf_q <= 1'b1;
    end
  end

  assign err_ovf = ovf_q;
  assign err_udf = udf_q;
`endif

endmodule

// File: tb/tb_sync_reg_queue.sv
// tb_sync_reg_queue
//   Directed plus random stimulus against a queue-based reference model of
//   the FWFT buffer. Optional feature macro: SYNC_REG_Q_ERR_EN.
module tb_sync_reg_queue;

  localparam int WIDTH    = 8;
  localparam int DEPTH    = 8;
  localparam int AF_LEVEL = DEPTH - 1;
  localparam int CW       = $clog2(DEPTH + 1);

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic             w_en = 1'b0;
  logic [WIDTH-1:0] w_data = '0;
  logic             r_en = 1'b0;
  logic [WIDTH-1:0] r_data;
  logic             r_empty;
  logic             w_full;
  logic             w_afull;
  logic [CW-1:0]    count;
`ifdef SYNC_REG_Q_ERR_EN
  logic             err_ovf;
  logic             err_udf;
`endif

  sync_reg_queue #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .w_en    (w_en),
    .w_data  (w_data),
    .r_en    (r_en),
    .r_data  (r_data),
    .r_empty (r_empty),
    .w_full  (w_full),
    .w_afull (w_afull),
    .count   (count)
`ifdef SYNC_REG_Q_ERR_EN
    ,
    .err_ovf (err_ovf),
    .err_udf (err_udf)
`endif
  );

  // scoreboard
  logic [WIDTH-1:0] exp_q[$];
  bit   exp_ovf = 1'b0;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every registered status output against the model; the head
  // word is compared only while the model holds data.
  task automatic check_status(input string tag);
    int n;
    n = exp_q.size();
    chk({tag, ".r_empty"}, {31'd0, r_empty}, {31'd0, n == 0});
    chk({tag, ".w_full"},  {31'd0, w_full},  {31'd0, n == DEPTH});
    chk({tag, ".w_afull"}, {31'd0, w_afull}, {31'd0, n >= AF_LEVEL});
    chk({tag, ".count"},   32'(count),       32'(n));
    if (n > 0) chk({tag, ".r_data"}, 32'(r_data), 32'(exp_q[0]));
`ifdef SYNC_REG_Q_ERR_EN
    chk({tag, ".err_ovf"}, {31'd0, err_ovf}, {31'd0, exp_ovf});
`endif
  endtask

  // driver: present one cycle of requests, advance the model, then check.
  // Called #1 after a rising edge so inputs settle well before the next one.
  task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r,
                      input string tag);
    bit ra, wa;
    w_en   = w;
    w_data = d;
    r_en   = r;
    ra = r && (exp_q.size() > 0);
    wa = w && ((exp_q.size() < DEPTH) || ra);
    if (w && (exp_q.size() == DEPTH) && !ra) exp_ovf = 1'b1;
    @(posedge clk);
    #1;
    if (ra) void'(exp_q.pop_front());
    if (wa) exp_q.push_back(d);
    w_en = 1'b0;
    r_en = 1'b0;
    check_status(tag);
  endtask

  initial begin
    // reset state
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_status("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // 1: single word in and out
    step(1'b1, 8'hBB, 1'b0, "t1_wr");
    step(1'b0, 8'h00, 1'b1, "t1_rd");

    // 2: fill to full, then drain in order
    for (int i = 1; i <= DEPTH; i++) step(1'b1, WIDTH'(i), 1'b0, "t2_fill");
    for (int i = 0; i < DEPTH; i++)  step(1'b0, 8'h00, 1'b1, "t2_drain");

    // 3: write while full is dropped
    for (int i = 1; i <= DEPTH; i++) step(1'b1, WIDTH'(8'h10 + i), 1'b0, "t3_fill");
    step(1'b1, 8'hFF, 1'b0, "t3_ovf");
    for (int i = 0; i < DEPTH; i++)  step(1'b0, 8'h00, 1'b1, "t3_drain");

    // 4: full with simultaneous write and read across pointer wrap
    for (int i = 1; i <= DEPTH; i++) step(1'b1, WIDTH'(8'h20 + i), 1'b0, "t4_fill");
    for (int i = 0; i < 20; i++)     step(1'b1, WIDTH'(8'h40 + i), 1'b1, "t4_stream");
    for (int i = 0; i < DEPTH; i++)  step(1'b0, 8'h00, 1'b1, "t4_drain");

    // 5: simultaneous write and read on empty: write only
    step(1'b1, 8'h5A, 1'b1, "t5_both");
    step(1'b0, 8'h00, 1'b1, "t5_rd");

    // 6: asynchronous reset mid-burst
    for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(8'h60 + i), 1'b0, "t6_fill");
    #2;
    rst = 1'b0;
    #1;
    exp_q.delete();
    exp_ovf = 1'b0;
    chk("t6_async.r_empty", {31'd0, r_empty}, 32'd1);
    chk("t6_async.count",   32'(count),       32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1'b1, 8'h33, 1'b0, "t6_wr");
    step(1'b0, 8'h00, 1'b1, "t6_rd");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
